// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_pkg : states, operation codes and stage decode for the        |
// |            calculator sequencer.            Revision: 1.0          |
// +--------------------------------------------------------------------+
package calc_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [3:0] OP_SUM   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_MOD   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_COUNT = 4'd10;

    // EXEC and SHOW share the last LED code
    function automatic logic [1:0] stage_of(input state_t s);
        case (s)
            LOAD_A:  stage_of = 2'd0;
            LOAD_B:  stage_of = 2'd1;
            LOAD_OP: stage_of = 2'd2;
            default: stage_of = 2'd3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_sequencer_if : board/ALU-side signal bundle of the sequencer. |
// |                                             Revision: 1.0          |
// +--------------------------------------------------------------------+
interface calc_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] sw;
    logic [3:0]   op_sw;
    logic         btn_enter;
    logic         btn_clear;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [3:0]   op_q;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;
    logic [1:0]   stage;
    logic         done;
    logic         err;

    modport master (
        input  sw, op_sw, btn_enter, btn_clear, alu_result, alu_flags,
        output a_q, b_q, op_q, result_q, flags_q, stage, done, err
    );

    modport slave (
        output sw, op_sw, btn_enter, btn_clear, alu_result, alu_flags,
        input  a_q, b_q, op_q, result_q, flags_q, stage, done, err
    );
endinterface
`default_nettype wire

// File: rtl/calc_sequencer_btn_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_pulse : debounces a raw button, one-cycle pulse per accepted   |
// |             press.                          Revision: 1.0          |
// +--------------------------------------------------------------------+
module btn_pulse #(
    parameter int DEBOUNCE = 250000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic raw,
    output logic      pulse
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] cnt;
    logic          level;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            // any sample matching the accepted level restarts the count
            if (raw != level) begin
                if (cnt == CW'(DEBOUNCE - 1)) begin
                    level <= raw;
                    cnt   <= '0;
                    pulse <= raw;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_sequencer : collects A, B, op from switches and latches the   |
// |                  ALU result for display.    Revision: 1.0          |
// +--------------------------------------------------------------------+
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int N        = 4,
    parameter int DEBOUNCE = 250000
) (
    input wire logic         clk,
    input wire logic         rst,
    calc_sequencer_if.master bus
);
    state_t       state, state_n;
    logic [N-1:0] a_r, a_n, b_r, b_n, res_r, res_n;
    logic [3:0]   op_r, op_n, fl_r, fl_n;
    logic         err_r, err_n;
    logic [1:0]   stage_r;
    logic         done_r;
    logic         enter_p, clear_p;

    btn_pulse #(.DEBOUNCE(DEBOUNCE)) u_enter (
        .clk(clk), .rst(rst), .raw(bus.btn_enter), .pulse(enter_p)
    );
    btn_pulse #(.DEBOUNCE(DEBOUNCE)) u_clear (
        .clk(clk), .rst(rst), .raw(bus.btn_clear), .pulse(clear_p)
    );

    always_comb begin
        state_n = state;
        a_n     = a_r;
        b_n     = b_r;
        op_n    = op_r;
        res_n   = res_r;
        fl_n    = fl_r;
        err_n   = err_r;
        if (clear_p) begin
            state_n = LOAD_A;
            a_n     = '0;
            b_n     = '0;
            op_n    = '0;
            res_n   = '0;
            fl_n    = '0;
            err_n   = 1'b0;
        end else begin
            case (state)
                LOAD_A: if (enter_p) begin
                    a_n     = bus.sw;
                    state_n = LOAD_B;
                end
                LOAD_B: if (enter_p) begin
                    b_n     = bus.sw;
                    state_n = LOAD_OP;
                end
                LOAD_OP: if (enter_p) begin
                    op_n    = bus.op_sw;
                    state_n = EXEC;
                end
                EXEC: begin
                    if (op_r < OP_COUNT) begin
                        res_n = bus.alu_result;
                        fl_n  = bus.alu_flags;
                        err_n = 1'b0;
                    end else begin
                        res_n = '0;
                        fl_n  = '0;
                        err_n = 1'b1;
                    end
                    state_n = SHOW;
                end
                SHOW: if (enter_p) begin
                    a_n     = res_r;
                    err_n   = 1'b0;
                    state_n = LOAD_B;
                end
                default: state_n = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= LOAD_A;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
            res_r   <= '0;
            fl_r    <= '0;
            err_r   <= 1'b0;
            stage_r <= 2'd0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            a_r     <= a_n;
            b_r     <= b_n;
            op_r    <= op_n;
            res_r   <= res_n;
            fl_r    <= fl_n;
            err_r   <= err_n;
            stage_r <= stage_of(state_n);
            done_r  <= (state == EXEC) && (state_n == SHOW);
        end
    end

    assign bus.a_q      = a_r;
    assign bus.b_q      = b_r;
    assign bus.op_q     = op_r;
    assign bus.result_q = res_r;
    assign bus.flags_q  = fl_r;
    assign bus.err      = err_r;
    assign bus.stage    = stage_r;
    assign bus.done     = done_r;
endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_calc_sequencer : directed bench with a behavioural 4-bit ALU.   |
// |                                             Revision: 1.0          |
// +--------------------------------------------------------------------+
module tb_calc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    calc_sequencer_if #(.N(4)) bus ();

    calc_sequencer #(.N(4), .DEBOUNCE(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // flags = {carry/borrow, zero, negative, signed overflow}
    always_comb begin
        logic [4:0] r;
        logic       v;
        r = 5'd0;
        v = 1'b0;
        case (bus.op_q)
            4'd0: begin
                r = {1'b0, bus.a_q} + {1'b0, bus.b_q};
                v = (bus.a_q[3] == bus.b_q[3]) && (r[3] != bus.a_q[3]);
            end
            4'd1: begin
                r = {1'b0, bus.a_q} - {1'b0, bus.b_q};
                v = (bus.a_q[3] != bus.b_q[3]) && (r[3] != bus.a_q[3]);
            end
            4'd2: r = {1'b0, 4'(bus.a_q * bus.b_q)};
            4'd3: r = (bus.b_q == 0) ? 5'd0 : {1'b0, bus.a_q / bus.b_q};
            4'd4: r = (bus.b_q == 0) ? 5'd0 : {1'b0, bus.a_q % bus.b_q};
            4'd5: r = {1'b0, bus.a_q & bus.b_q};
            4'd6: r = {1'b0, bus.a_q | bus.b_q};
            4'd7: r = {1'b0, bus.a_q ^ bus.b_q};
            4'd8: r = {1'b0, bus.a_q << 1};
            4'd9: r = {1'b0, bus.a_q >> 1};
            default: r = 5'h1f;
        endcase
        bus.alu_result = r[3:0];
        bus.alu_flags  = {r[4], (r[3:0] == 4'd0), r[3], v};
    end

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_enter(input int hold);
        @(negedge clk) bus.btn_enter = 1'b1;
        repeat (hold) @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_clear();
        @(negedge clk) bus.btn_clear = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_clear = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.sw        = 4'd0;
        bus.op_sw     = 4'd0;
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle", {bus.a_q, bus.b_q, bus.op_q, bus.result_q,
                               bus.flags_q, bus.stage, bus.done, bus.err}, 32'd0);
        end

        // 3 + 5
        bus.sw = 4'd3; press_enter(4);
        chk("add_stage_b", bus.stage, 2'd1);
        chk("add_a", bus.a_q, 4'd3);
        bus.sw = 4'd5; press_enter(4);
        chk("add_stage_op", bus.stage, 2'd2);
        chk("add_b", bus.b_q, 4'd5);
        bus.sw = 4'd0; bus.op_sw = 4'd0; press_enter(4);
        chk("add_stage_show", bus.stage, 2'd3);
        chk("add_result", bus.result_q, 4'd8);
        chk("add_flags", bus.flags_q, 4'b0011);
        chk("add_err", bus.err, 1'b0);
        chk("add_done_cnt", done_cnt, 1);

        // 15 + 1 wraps, then chain 0 - 7
        press_clear();
        chk("clr_stage", bus.stage, 2'd0);
        chk("clr_regs", {bus.a_q, bus.b_q, bus.result_q, bus.flags_q}, 16'd0);
        bus.sw = 4'd15; press_enter(4);
        bus.sw = 4'd1;  press_enter(4);
        bus.op_sw = 4'd0; press_enter(4);
        chk("wrap_result", bus.result_q, 4'd0);
        chk("wrap_flags", bus.flags_q, 4'b1100);
        chk("wrap_done_cnt", done_cnt, 2);
        bus.sw = 4'd11; press_enter(4);
        chk("chain_stage", bus.stage, 2'd1);
        chk("chain_a", bus.a_q, 4'd0);
        bus.sw = 4'd7; press_enter(4);
        bus.op_sw = 4'd1; press_enter(4);
        chk("sub_result", bus.result_q, 4'd9);
        chk("sub_flags", bus.flags_q, 4'b1010);
        chk("sub_done_cnt", done_cnt, 3);

        // invalid op 12
        press_enter(4);
        chk("chain2_a", bus.a_q, 4'd9);
        bus.sw = 4'd2; press_enter(4);
        bus.op_sw = 4'd12; press_enter(4);
        chk("inv_stage", bus.stage, 2'd3);
        chk("inv_err", bus.err, 1'b1);
        chk("inv_result", bus.result_q, 4'd0);
        chk("inv_flags", bus.flags_q, 4'd0);
        chk("inv_done_cnt", done_cnt, 4);
        press_enter(4);
        chk("inv_chain_err", bus.err, 1'b0);
        chk("inv_chain_stage", bus.stage, 2'd1);
        chk("inv_chain_a", bus.a_q, 4'd0);

        // bounce: no capture; long hold: one capture
        bus.sw = 4'd13;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) bus.btn_enter = ~bus.btn_enter;
        end
        bus.btn_enter = 1'b0;
        repeat (4) @(negedge clk);
        chk("bounce_stage", bus.stage, 2'd1);
        chk("bounce_b", bus.b_q, 4'd2);
        bus.sw = 4'd6; press_enter(50);
        chk("hold_stage", bus.stage, 2'd2);
        chk("hold_b", bus.b_q, 4'd6);

        // clear and enter together in LOAD_B
        press_clear();
        bus.sw = 4'd4; press_enter(4);
        chk("ce_pre_stage", bus.stage, 2'd1);
        bus.sw = 4'd9;
        @(negedge clk);
        bus.btn_enter = 1'b1;
        bus.btn_clear = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (4) @(negedge clk);
        chk("ce_stage", bus.stage, 2'd0);
        chk("ce_b", bus.b_q, 4'd0);
        chk("ce_a", bus.a_q, 4'd0);

        // reset while in EXEC
        bus.sw = 4'd2; press_enter(4);
        bus.sw = 4'd3; press_enter(4);
        bus.op_sw = 4'd2;
        @(negedge clk) bus.btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        chk("exec_stage", bus.stage, 2'd3);
        chk("exec_done_low", bus.done, 1'b0);
        chk("exec_done_cnt", done_cnt, 4);
        rst = 1'b0;
        bus.btn_enter = 1'b0;
        @(negedge clk);
        chk("rst_exec_outs", {bus.a_q, bus.b_q, bus.op_q, bus.result_q,
                              bus.flags_q, bus.stage, bus.done, bus.err}, 32'd0);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_exec_done_cnt", done_cnt, 4);
        chk("rst_exec_stage", bus.stage, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
# calc_sequencer

Sequential front end for the N-bit ALU calculator. It collects operand A, operand B and a 4-bit operation code from board switches using a debounced "enter" button. It drives the ALU/flag multiplexer inputs from registers, then latches the selected result and flags for the 7-segment decoder and flag LEDs. It also supports chaining, where the previous result becomes the next operand A, and a clear button.

## Interface
- `N`, 4, operand/result width
- `DEBOUNCE`, 250000, consecutive stable samples required to accept a button level change (≥1)
- `clk` input 1: system clock
- `rst` input 1: synchronous, active-low reset
- `sw` input N: operand switches
- `op_sw` input 4: operation switches
- `btn_enter` input 1: raw enter button, active-high
- `btn_clear` input 1: raw clear button, active-high
- `alu_result` input N: muxed ALU result for `op_q`
- `alu_flags` input 4: muxed flags for `op_q`
- `a_q` output N: registered operand A to ALU
- `b_q` output N: registered operand B to ALU
- `op_q` output 4: registered operation select to both muxes
- `result_q` output N: latched result, to decoder
- `flags_q` output 4: latched flags
- `stage` output 2: 0=LOAD_A, 1=LOAD_B, 2=LOAD_OP, 3=EXEC/SHOW (LEDs)
- `done` output 1: one-cycle pulse on entering SHOW
- `err` output 1: high in SHOW when the latched op was invalid

## Operation
- Reset (`rst`=0 at a clock edge): state LOAD_A; all registers and outputs 0; `err`=0; debouncers cleared (button considered released).
- Each button goes through its own debouncer. It emits a one-cycle pulse when the input has been sampled high for `DEBOUNCE` consecutive cycles after a debounced low. A held button produces one pulse only. Release requires `DEBOUNCE` consecutive low samples.
- States and transitions:
  - LOAD_A: on enter pulse, `a_q`←`sw`; go to LOAD_B.
  - LOAD_B: on enter pulse, `b_q`←`sw`; go to LOAD_OP.
  - LOAD_OP: on enter pulse, `op_q`←`op_sw`; go to EXEC.
  - EXEC: exactly one cycle.
    - If `op_q`≤9: `result_q`←`alu_result`, `flags_q`←`alu_flags`, `err`←0.
    - If `op_q`≥10: `result_q`←0, `flags_q`←0, `err`←1.
    - Go to SHOW.
  - SHOW: hold all outputs. On enter pulse, chain: `a_q`←`result_q`, `err`←0, go to LOAD_B.
- Clear pulse, in any state: `a_q`,`b_q`,`op_q`,`result_q`,`flags_q`,`err`←0; go to LOAD_A.
- Clear and enter pulses in the same cycle: clear wins and enter is discarded.
- Enter pulse during EXEC is ignored and not queued.
- `sw`/`op_sw` changes outside the capture cycle have no effect.
- Width rules:
  - All data paths are N bits, with no extension or truncation internally.
  - The ALU is combinational. `a_q`/`b_q`/`op_q` are stable for the whole EXEC cycle, so `alu_result` is valid there.

## Timing
- Enter/clear latency: raw rising edge at cycle t with input held high. Pulse at cycle t+`DEBOUNCE`; register update and state change at the following edge.
- From the LOAD_OP capture edge: EXEC for one cycle. `result_q`/`flags_q` update and SHOW is entered at the next edge.
- `done` is high for exactly the first cycle of SHOW.
- `stage` is a registered decode of state, with no glitches.
- Reset mid-operation (including EXEC) overrides everything in that cycle. It takes priority over clear and enter.

## Structure
- Package `calc_pkg`:
  - state enum: LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW
  - operation codes OP_SUM=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_MOD=4, OP_AND=5, OP_OR=6, OP_XOR=7, OP_SHL=8, OP_SHR=9
  - OP_COUNT=10
- Sub-module `btn_pulse` #(`DEBOUNCE`): one counter plus a stable-level register, output is a one-shot pulse. Instantiated twice.
- Top-level composition: `calc_sequencer` feeds the existing ALU, both multiplexers and the decoder.

## Test plan
All scenarios use `DEBOUNCE`=2 and a behavioural ALU model.
- Reset then idle: all outputs 0, `stage`=0, `done`=0 for 20 cycles.
- Basic add: A=3, B=5, op=0, each entered by a 4-cycle press → `result_q`=8, `flags_q` equals the model's flags, and `done` pulses once on SHOW entry.
- Wrap and chain: A=15, B=1, op=0 gives `result_q`=0 with the model's carry and zero flags. Then enter chains with A=0, B=7, op=1 → `result_q`=9 (0−7 mod 16), `a_q`=0 at chain.
- Invalid op: op=12 → SHOW with `err`=1, `result_q`=0, `flags_q`=0. The next chain enter clears `err`.
- Bounce and hold: enter toggled every cycle for 10 cycles → no capture. A button held for 50 cycles → exactly one capture.
- Clear/reset precedence:
  - Clear and enter pulse in the same cycle in LOAD_B → state LOAD_A, `b_q` unchanged at 0.
  - `rst`=0 asserted during EXEC → all outputs 0 next cycle, `done` never pulses.
